// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch front end
//
// Purpose: FSM state encoding, default bus widths and the prefetch queue
//          entry layout used by fetch_unit, fetch_if and the testbench.
// Ports:   none (package).
package fetch_pkg;

   localparam int FETCH_ADDR_W = 8;
   localparam int FETCH_DATA_W = 16;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_REQ   = 2'd1,
      FETCH_DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - bundle of program counter, memory and decoder signals of the fetch unit
//
// Purpose: groups every non-clock/reset signal of fetch_unit.
// Ports:   master = fetch unit view (drives mem_req/mem_addr, enable_increment,
//          instr_valid/instr_data/instr_pc); slave = environment view.
interface fetch_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int DATA_W = FETCH_DATA_W
) ();

   logic [ADDR_W-1:0] pc;
   logic              enable_increment;
   logic              flush;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_pc;

   modport master (
      input  pc, flush, mem_ack, mem_rdata, instr_ready,
      output enable_increment, mem_req, mem_addr, instr_valid, instr_data, instr_pc
   );

   modport slave (
      output pc, flush, mem_ack, mem_rdata, instr_ready,
      input  enable_increment, mem_req, mem_addr, instr_valid, instr_data, instr_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO holding prefetched {pc, data} words
//
// Purpose: DEPTH-entry queue, power-of-two depth, wrapping pointers.
// Ports:   clk, reset (async active-low); push/push_data write the tail;
//          pop retires the head; clear empties the queue on the next edge
//          and takes priority over push/pop; full, empty, head (current head word).
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             clear,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_en;
   logic             pop_en;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_en && !pop_en)      count_d = count_q + CNT_W'(1);
         else if (pop_en && !push_en) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_en && !clear) mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end between program counter, memory and decoder
//
// Purpose: issues one memory read at a time at the current pc, queues returned
//          words with their pc for the decoder and pulses enable_increment
//          once per accepted fetch; flush discards queue and in-flight data.
// Ports:   clk, reset (async active-low); bus (fetch_if.master): pc, flush,
//          mem_req/mem_addr/mem_ack/mem_rdata, enable_increment,
//          instr_valid/instr_ready/instr_data/instr_pc.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int DATA_W = FETCH_DATA_W,
   parameter int DEPTH  = 2
) (
   input logic      clk,
   input logic      reset,
   fetch_if.master  bus
);

   fetch_state_e             state_q, state_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic                     take;
   logic                     full;
   logic                     empty;
   logic [ADDR_W+DATA_W-1:0] head;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      take    = 1'b0;
      unique case (state_q)
         FETCH_IDLE: begin
            // Space is checked here, so the single in-flight word always fits.
            if (!bus.flush && !full) begin
               addr_d  = bus.pc;
               state_d = FETCH_REQ;
            end
         end
         FETCH_REQ: begin
            if (bus.mem_ack) begin
               take    = !bus.flush;
               state_d = FETCH_IDLE;
            end else if (bus.flush) begin
               state_d = FETCH_DRAIN;
            end
         end
         FETCH_DRAIN: begin
            // Memory still owes one beat; swallow it without incrementing.
            if (bus.mem_ack) state_d = FETCH_IDLE;
         end
         default: state_d = FETCH_IDLE;
      endcase
   end

   assign bus.mem_req          = (state_q != FETCH_IDLE);
   assign bus.mem_addr         = addr_q;
   assign bus.enable_increment = take;
   assign bus.instr_valid      = !empty;
   assign bus.instr_pc         = head[ADDR_W+DATA_W-1 -: ADDR_W];
   assign bus.instr_data       = head[DATA_W-1:0];

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (take),
      .push_data ({addr_q, bus.mem_rdata}),
      .pop       (!empty && bus.instr_ready),
      .clear     (bus.flush),
      .full      (full),
      .empty     (empty),
      .head      (head)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 2;

   logic clk;
   logic reset;

   fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   lat       = 1;
   int   age       = 0;
   int   inc_count = 0;
   logic inc_pending = 1'b0;

   // Reference: one optional outstanding read plus an ordered list of words.
   logic              m_inflight;
   logic              m_discard;
   logic [ADDR_W-1:0] m_addr;
   fetch_entry_t      m_q[$];
   int                log_pc[$];
   int                log_cyc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      m_inflight = 1'b0;
      m_discard  = 1'b0;
      m_addr     = '0;
      m_q.delete();
   endtask

   task automatic model_compare();
      logic exp_inc;
      exp_inc = m_inflight && !m_discard && bus.mem_ack && !bus.flush;
      chk("mem_req", bus.mem_req, m_inflight);
      if (m_inflight) chk("mem_addr", bus.mem_addr, m_addr);
      chk("enable_increment", bus.enable_increment, exp_inc);
      chk("instr_valid", bus.instr_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
         chk("instr_pc", bus.instr_pc, m_q[0].pc);
         chk("instr_data", bus.instr_data, m_q[0].data);
      end
   endtask

   // Advance the reference across one rising edge using the current inputs.
   task automatic model_edge();
      logic         taken;
      int           sz;
      fetch_entry_t e;
      taken = m_inflight && !m_discard && bus.mem_ack && !bus.flush;
      sz    = m_q.size();
      if (bus.flush) begin
         m_q.delete();
      end else begin
         if (sz != 0 && bus.instr_ready) void'(m_q.pop_front());
         if (taken) begin
            e.pc   = m_addr;
            e.data = bus.mem_rdata;
            m_q.push_back(e);
         end
      end
      if (m_inflight) begin
         if (bus.mem_ack)    m_inflight = 1'b0;
         else if (bus.flush) m_discard  = 1'b1;
      end else if (!bus.flush && sz < DEPTH) begin
         m_inflight = 1'b1;
         m_discard  = 1'b0;
         m_addr     = bus.pc;
      end
   endtask

   task automatic cycle(input logic fl, input logic rdy, input logic stray);
      @(negedge clk);
      if (inc_pending && reset) bus.pc = bus.pc + 8'd1;
      inc_pending     = 1'b0;
      bus.flush       = fl;
      bus.instr_ready = rdy;
      if (bus.mem_req) age++;
      else             age = 0;
      bus.mem_ack   = stray || (bus.mem_req && age >= lat);
      bus.mem_rdata = 16'hA000 + {8'h00, bus.mem_addr};
      #1;
      if (!reset) begin
         chk("rst_mem_req", bus.mem_req, 0);
         chk("rst_mem_addr", bus.mem_addr, 0);
         chk("rst_enable_increment", bus.enable_increment, 0);
         chk("rst_instr_valid", bus.instr_valid, 0);
         chk("rst_instr_data", bus.instr_data, 0);
         chk("rst_instr_pc", bus.instr_pc, 0);
         model_clear();
         age = 0;
      end else begin
         model_compare();
         if (bus.instr_valid && rdy && !fl) begin
            log_pc.push_back(int'(bus.instr_pc));
            log_cyc.push_back(cyc);
         end
         if (bus.enable_increment) begin
            inc_pending = 1'b1;
            inc_count++;
         end
         model_edge();
      end
      cyc++;
   endtask

   task automatic release_reset(input logic fl);
      bus.flush   = fl;
      bus.mem_ack = 1'b0;
      reset       = 1'b1;
      model_edge();
   endtask

   task automatic do_reset(input logic [ADDR_W-1:0] start_pc);
      reset           = 1'b0;
      bus.flush       = 1'b0;
      bus.mem_ack     = 1'b0;
      bus.instr_ready = 1'b0;
      inc_pending     = 1'b0;
      inc_count       = 0;
      age             = 0;
      log_pc.delete();
      log_cyc.delete();
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      bus.pc = start_pc;
      release_reset(1'b0);
   endtask

   initial begin
      reset           = 1'b0;
      bus.pc          = '0;
      bus.flush       = 1'b0;
      bus.mem_ack     = 1'b0;
      bus.mem_rdata   = '0;
      bus.instr_ready = 1'b0;
      model_clear();

      // Reset and first fetch, 1-cycle memory
      lat = 1;
      do_reset(8'h00);
      cycle(1'b0, 1'b0, 1'b0);
      chk("first_req", bus.mem_req, 1);
      chk("first_addr", bus.mem_addr, 8'h00);
      chk("first_inc", bus.enable_increment, 1);
      cycle(1'b0, 1'b0, 1'b0);
      chk("first_valid", bus.instr_valid, 1);
      chk("first_pc", bus.instr_pc, 8'h00);

      // Fill and stall with the decoder blocked
      repeat (10) cycle(1'b0, 1'b0, 1'b0);
      chk("fill_pc", bus.pc, 8'h02);
      chk("fill_incs", inc_count, 2);
      chk("fill_req_low", bus.mem_req, 0);
      chk("fill_head_data", bus.instr_data, 16'hA000);

      // Streaming with the decoder always ready
      do_reset(8'h00);
      repeat (8) cycle(1'b0, 1'b1, 1'b0);
      chk("stream_count", log_pc.size() >= 3, 1);
      for (int i = 0; i < 3; i++) begin
         if (log_pc.size() > i) chk("stream_order", log_pc[i], i);
         if (log_pc.size() > i + 1) chk("stream_spacing", log_cyc[i+1] - log_cyc[i], 2);
      end

      // Flush while a 3-cycle read is pending
      do_reset(8'h00);
      cycle(1'b0, 1'b0, 1'b0);
      lat = 3;
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      chk("flush_valid_before", bus.instr_valid, 1);
      bus.pc = 8'h40;
      cycle(1'b0, 1'b0, 1'b0);
      chk("flush_q_empty", bus.instr_valid, 0);
      chk("flush_req_held", bus.mem_req, 1);
      cycle(1'b0, 1'b0, 1'b0);
      chk("drain_ack_seen", bus.mem_ack, 1);
      chk("drain_no_inc", bus.enable_increment, 0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("drain_idle", bus.mem_req, 0);
      chk("drain_no_push", bus.instr_valid, 0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("refetch_req", bus.mem_req, 1);
      chk("refetch_addr", bus.mem_addr, 8'h40);
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      chk("refetch_head_pc", bus.instr_pc, 8'h40);
      chk("refetch_head_data", bus.instr_data, 16'hA040);
      chk("flush_incs", inc_count, 2);

      // Ack and flush in the same cycle
      lat = 1;
      do_reset(8'h20);
      cycle(1'b1, 1'b0, 1'b0);
      chk("simul_ack", bus.mem_ack, 1);
      chk("simul_no_inc", bus.enable_increment, 0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("simul_idle", bus.mem_req, 0);
      chk("simul_no_push", bus.instr_valid, 0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("simul_readdr", bus.mem_addr, 8'h20);
      chk("simul_inc", bus.enable_increment, 1);
      cycle(1'b0, 1'b0, 1'b0);
      chk("simul_head_pc", bus.instr_pc, 8'h20);

      // Asynchronous reset in the middle of a request
      lat = 1;
      do_reset(8'h30);
      cycle(1'b0, 1'b0, 1'b0);
      lat = 3;
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("pre_reset_req", bus.mem_req, 1);
      chk("pre_reset_valid", bus.instr_valid, 1);
      #1 reset = 1'b0;
      #1;
      chk("areset_req", bus.mem_req, 0);
      chk("areset_valid", bus.instr_valid, 0);
      model_clear();
      inc_pending = 1'b0;
      inc_count   = 0;
      age         = 0;
      cycle(1'b0, 1'b0, 1'b0);
      bus.pc = 8'h50;
      release_reset(1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("stray_inc", bus.enable_increment, 0);
      chk("stray_req", bus.mem_req, 0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("post_stray_req", bus.mem_req, 1);
      chk("post_stray_addr", bus.mem_addr, 8'h50);
      chk("post_stray_no_push", bus.instr_valid, 0);
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      chk("post_stray_head", bus.instr_pc, 8'h50);
      chk("post_stray_incs", inc_count, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that consumes the program counter. It reads instruction memory at the current `pc` over a req/ack handshake and buffers fetched words with their PC in a small queue for the decoder. It drives `enable_increment` back to the program counter once per accepted fetch. It sits between the program counter, instruction memory and the decoder.

## Interface

- `ADDR_W`, 8, width of `pc` and memory address
- `DATA_W`, 16, instruction word width
- `DEPTH`, 2, prefetch queue entries (power of 2, ≥2)

Ports:

- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; asserting it clears all state immediately
- `pc` in ADDR_W: current program counter value
- `enable_increment` out 1: one-cycle pulse telling the program counter to advance
- `flush` in 1: discard queued instructions and any in-flight fetch
- `mem_req` out 1: memory read request
- `mem_addr` out ADDR_W: read address, held stable while `mem_req` is high
- `mem_ack` in 1: memory data valid this cycle; variable latency, ≥1 cycle after `mem_req` rises
- `mem_rdata` in DATA_W: read data, sampled when `mem_ack` is high
- `instr_valid` out 1: queue head is valid
- `instr_ready` in 1: decoder accepts the head this cycle
- `instr_data` out DATA_W: head instruction word
- `instr_pc` out ADDR_W: PC of the head instruction

## Operation

FSM states are IDLE, REQ and DRAIN.

- **IDLE:**
  - If `!flush` and `count < DEPTH`: latch `mem_addr <= pc` and raise `mem_req`, then go to REQ.
  - Otherwise stay in IDLE.
- **REQ:**
  - `mem_req` stays high and `mem_addr` stays frozen until `mem_ack`.
  - On `mem_ack && !flush`: push {`mem_addr`, `mem_rdata`} into the queue, drop `mem_req`, go to IDLE.
  - `enable_increment = (state==REQ) && mem_ack && !flush`. This is combinational, so the program counter advances on the same edge the ack is taken.
- **Flush in REQ:**
  - If `flush` arrives without `mem_ack`: go to DRAIN.
  - If `flush` and `mem_ack` occur together: drop the data, no increment, go to IDLE.
- **DRAIN:**
  - `mem_req` stays high until `mem_ack`.
  - Returned data is discarded and no increment is issued.
  - Then go to IDLE.
  - A further `flush` while in DRAIN has no extra effect.
- **Flush and the queue:** `flush` empties the queue on the next edge, regardless of state or `instr_ready`. While `flush` is high, no new request is issued.
- **Queue:**
  - `instr_valid = count != 0`.
  - A pop occurs on `instr_valid && instr_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
  - A push never meets a full queue, because a request is issued only when `count < DEPTH`.
- **Credit rule:** at most one outstanding request. The IDLE space check makes overflow impossible, since at most one word is ever in flight.
- **Arithmetic:** `count` is `$clog2(DEPTH)+1` bits. Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.

## Timing

- **Reset values:** all outputs are 0. FSM is IDLE, `count` is 0, pointers are 0.
- **First request:** the first edge after reset release with `flush` low raises `mem_req`.
- **Ack to data:** an ack at edge N makes the word visible at the queue head after edge N (`instr_valid` high in cycle N+1 if the queue was empty).
- **Back-to-back fetches:** minimum 2 cycles from one request to the next. The ack edge returns the FSM to IDLE, and the next edge issues with the updated `pc`.
- **Throughput:** peak is 1 instruction per 2 cycles with a 1-cycle memory.
- **Reset mid-operation:** the queue empties and `mem_req` drops asynchronously. A late `mem_ack` after reset release is ignored while in IDLE.

## Structure

- **Package `fetch_pkg`:**
  - FSM state enum (`FETCH_IDLE`, `FETCH_REQ`, `FETCH_DRAIN`)
  - default `ADDR_W`/`DATA_W` localparams
  - queue entry struct {pc, data}
- **Sub-module `fetch_fifo`:**
  - synchronous FIFO with DEPTH and width `ADDR_W+DATA_W`
  - ports: push, pop, clear, full, empty, head
  - same clock and active-low async reset
- **Top level:** `fetch_unit` contains the FSM, the address register and the increment logic.

## Test plan

- **Reset and first fetch:** assert reset with `pc=0x00`, 1-cycle memory. Required: outputs 0 during reset; `mem_req=1`, `mem_addr=0x00` on the first edge after release; after the ack edge, one `enable_increment` pulse and `instr_pc=0x00`.
- **Fill and stall:** hold `instr_ready=0` with memory returning 0xA000+pc. Required: exactly 2 fetches (pc 0x00, 0x01); `mem_req` stays 0 while the queue is full; `pc` stops at 0x02.
- **Streaming:** `instr_ready=1` with a 1-cycle memory. Required: instructions for pc 0x00, 0x01, 0x02 arrive in order, spaced by 2 cycles, with no duplicates or gaps.
- **Flush while pending:** 3-cycle memory, `flush` pulsed in cycle 1 of REQ. Required:
  - queue empty next cycle;
  - `mem_req` held until ack;
  - no `enable_increment`;
  - data not enqueued;
  - next request uses the new `pc=0x40`.
- **Simultaneous ack and flush:** same cycle. Required: no increment, no push, FSM goes to IDLE.
- **Async reset mid-REQ:** assert `reset` low between edges. Required: `mem_req` and `instr_valid` drop immediately; a subsequent stray `mem_ack` is ignored.
